// File: rtl/lfsr_burst_frame_gen.sv
// AXI4-Stream traffic source: variable-length packets whose payload is a continuous 16-bit LFSR
// stream, with tkeep/tuser metadata, inter-packet gaps and an optional packet-count limit.
module lfsr_burst_frame_gen #(
  parameter int          C_PORT_NUMBER         = 0,
  parameter int          C_INPORT_WIDTH        = 3,
  parameter int          C_OUTPORT_WIDTH       = 8,
  parameter int          C_PACKET_LENGTH_WIDTH = 14,
  parameter int          C_AXIS_DATA_WIDTH     = 256,
  parameter logic [15:0] C_SEED                = 16'hABCD,
  parameter int          C_MIN_LEN             = 64,
  parameter int          C_MAX_LEN             = 1518
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               cfg_random_len,
  input  logic [C_PACKET_LENGTH_WIDTH-1:0]   cfg_length,
  input  logic [7:0]                         cfg_gap,
  input  logic [31:0]                        cfg_pkt_limit,
  input  logic [C_OUTPORT_WIDTH-1:0]         cfg_out_port,
  output logic [C_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_PACKET_LENGTH_WIDTH-1:0]   m_axis_tuser_packet_length,
  output logic [C_INPORT_WIDTH-1:0]          m_axis_tuser_in_port,
  output logic [C_OUTPORT_WIDTH-1:0]         m_axis_tuser_out_port,
  output logic [C_INPORT_WIDTH-1:0]          m_axis_tuser_in_vport,
  output logic [C_OUTPORT_WIDTH-1:0]         m_axis_tuser_out_vport,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [31:0]                        pkt_count,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         dbg_state_o
);
  localparam int BYTES = C_AXIS_DATA_WIDTH / 8;
  localparam int WORDS = C_AXIS_DATA_WIDTH / 16;
  localparam int PLW   = C_PACKET_LENGTH_WIDTH;
  localparam logic [15:0] LEN_SEED = 16'h1D0F;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  // w[15] holds LFSR bit 0, so taps b3/b12/b14/b15 sit at w[12]/w[3]/w[1]/w[0].
  function automatic logic [15:0] lfsr_step(input logic [15:0] w);
    return {~(w[12] ^ w[3] ^ w[1] ^ w[0]), w[15:1]};
  endfunction

  state_t                     state_q, state_d;
  logic [15:0]                data_lfsr_q, data_lfsr_d;
  logic [15:0]                len_lfsr_q, len_lfsr_d;
  logic [PLW-1:0]             len_q, len_d;
  logic [PLW-1:0]             beats_last_q, beats_last_d;
  logic [PLW-1:0]             beat_cnt_q, beat_cnt_d;
  logic [C_OUTPORT_WIDTH-1:0] out_port_q, out_port_d;
  logic [7:0]                 gap_q, gap_d;
  logic [31:0]                pkt_count_q, pkt_count_d, pkt_count_inc;
  logic [31:0]                rand_sum;
  logic [PLW-1:0]             rand_len, start_len, last_rem;
  logic [BYTES-1:0]           keep_all;
  logic                       accept, last_beat, done_next, start;

  assign keep_all      = '1;
  assign rand_sum      = 32'(C_MIN_LEN) + 32'(len_lfsr_q[10:0]);
  assign rand_len      = (rand_sum > 32'(C_MAX_LEN)) ? PLW'(C_MAX_LEN) : rand_sum[PLW-1:0];
  assign start_len     = cfg_random_len ? rand_len :
                         ((cfg_length == '0) ? PLW'(1) : cfg_length);
  assign last_beat     = (beat_cnt_q == beats_last_q);
  assign last_rem      = PLW'(32'(len_q) % 32'(BYTES));
  assign pkt_count_inc = (&pkt_count_q) ? pkt_count_q : pkt_count_q + 32'd1;
  assign done          = (cfg_pkt_limit != '0) && (pkt_count_q == cfg_pkt_limit);
  assign done_next     = (cfg_pkt_limit != '0) && (pkt_count_inc == cfg_pkt_limit);

  // A beat transfers when tvalid & tready; once raised, tvalid and the whole beat
  // (tdata/tkeep/tlast/tuser) hold until that transfer, since every source register
  // only moves on accept.
  assign accept        = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid              = (state_q == SEND);
  assign m_axis_tlast               = m_axis_tvalid && last_beat;
  assign m_axis_tdata               = {WORDS{data_lfsr_q}};
  assign m_axis_tkeep               = (m_axis_tlast && (last_rem != '0)) ?
                                      ~(keep_all << last_rem) : keep_all;
  assign m_axis_tuser_packet_length = len_q;
  assign m_axis_tuser_in_port       = C_INPORT_WIDTH'(C_PORT_NUMBER);
  assign m_axis_tuser_out_port      = out_port_q;
  assign m_axis_tuser_in_vport      = '0;
  assign m_axis_tuser_out_vport     = '0;
  assign pkt_count                  = pkt_count_q;
  assign busy                       = (state_q != IDLE);
  assign dbg_state_o                = state_q;

  always_comb begin
    state_d      = state_q;
    data_lfsr_d  = data_lfsr_q;
    len_lfsr_d   = len_lfsr_q;
    len_d        = len_q;
    beats_last_d = beats_last_q;
    beat_cnt_d   = beat_cnt_q;
    out_port_d   = out_port_q;
    gap_d        = gap_q;
    pkt_count_d  = pkt_count_q;
    start        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !done) begin
          start   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          data_lfsr_d = lfsr_step(data_lfsr_q);
          if (last_beat) begin
            pkt_count_d = pkt_count_inc;
            if (cfg_gap != '0) begin
              state_d = GAP;
              gap_d   = cfg_gap;
            end else if (enable && !done_next) begin
              start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + PLW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    // Packet parameters are captured only here, so cfg changes mid-packet wait for the next start.
    if (start) begin
      len_d        = start_len;
      beats_last_d = PLW'((32'(start_len) + 32'(BYTES - 1)) / 32'(BYTES) - 32'd1);
      beat_cnt_d   = '0;
      out_port_d   = cfg_out_port;
      len_lfsr_d   = lfsr_step(len_lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_lfsr_q  <= C_SEED;
      len_lfsr_q   <= LEN_SEED;
      len_q        <= '0;
      beats_last_q <= '0;
      beat_cnt_q   <= '0;
      out_port_q   <= '0;
      gap_q        <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_lfsr_q  <= data_lfsr_d;
      len_lfsr_q   <= len_lfsr_d;
      len_q        <= len_d;
      beats_last_q <= beats_last_d;
      beat_cnt_q   <= beat_cnt_d;
      out_port_q   <= out_port_d;
      gap_q        <= gap_d;
      pkt_count_q  <= pkt_count_d;
    end
  end
endmodule

// File: tb/tb_lfsr_burst_frame_gen.sv
// Scoreboard bench for lfsr_burst_frame_gen: directed packets push expected beats, a negedge
// monitor pops and compares on every accepted beat and checks stall stability and gap lengths.
module tb_lfsr_burst_frame_gen;
  localparam int W  = 256;
  localparam int KB = W / 8;
  localparam int EW = 71; // {word16, keep32, last1, len14, out_port8}

  logic         clk, reset, enable, cfg_random_len;
  logic [13:0]  cfg_length;
  logic [7:0]   cfg_gap;
  logic [31:0]  cfg_pkt_limit;
  logic [7:0]   cfg_out_port;
  logic [W-1:0] tdata;
  logic [31:0]  tkeep;
  logic [13:0]  t_len;
  logic [2:0]   t_in_port, t_in_vport;
  logic [7:0]   t_out_port, t_out_vport;
  logic         tvalid, tready, tlast;
  logic [31:0]  pkt_count;
  logic         busy, done;
  logic [1:0]   dbg_state;

  lfsr_burst_frame_gen #(
    .C_PORT_NUMBER(0), .C_INPORT_WIDTH(3), .C_OUTPORT_WIDTH(8), .C_PACKET_LENGTH_WIDTH(14),
    .C_AXIS_DATA_WIDTH(W), .C_SEED(16'hABCD), .C_MIN_LEN(64), .C_MAX_LEN(1518)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_random_len(cfg_random_len),
    .cfg_length(cfg_length), .cfg_gap(cfg_gap), .cfg_pkt_limit(cfg_pkt_limit),
    .cfg_out_port(cfg_out_port), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
    .m_axis_tuser_packet_length(t_len), .m_axis_tuser_in_port(t_in_port),
    .m_axis_tuser_out_port(t_out_port), .m_axis_tuser_in_vport(t_in_vport),
    .m_axis_tuser_out_vport(t_out_vport), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .pkt_count(pkt_count), .busy(busy), .done(done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [15:0]   model_lfsr = 16'hABCD;
  logic [15:0]   mon_lfsr = 16'hABCD;
  int            exp_idle = -1;
  bit            rnd_ready = 0;
  bit            rnd_mode = 0;
  int            rnd_pkts = 0;
  int            beat_idx = 0;
  int            cur_len = 0;
  int            idle_run = 0;
  bit            after_last = 0;
  bit            stall_prev = 0;
  logic [310:0]  prev_vec;
  logic [EW-1:0] e;
  logic [31:0]   rkeep;
  bit            rlast;

  // Reference LFSR written with the [0:15] bit numbering of the payload definition.
  function automatic logic [15:0] lfsr_next(input logic [15:0] w);
    logic [0:15] b, n;
    b = w;
    n = {~(b[3] ^ b[12] ^ b[14] ^ b[15]), b[0:14]};
    return n;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_beat(input logic [15:0] w, input logic [31:0] k, input logic l,
                           input logic [13:0] len, input logic [7:0] op);
    exp_q.push_back({w, k, l, len, op});
  endtask

  task automatic push_packet(input int len);
    int eff, nb, rem;
    logic [31:0] k;
    eff = (len == 0) ? 1 : len;
    nb  = (eff + KB - 1) / KB;
    rem = eff % KB;
    for (int b = 0; b < nb; b++) begin
      k = ((b == nb - 1) && (rem != 0)) ? ((32'h1 << rem) - 32'h1) : 32'hFFFF_FFFF;
      push_beat(model_lfsr, k, (b == nb - 1), 14'(eff), cfg_out_port);
      model_lfsr = lfsr_next(model_lfsr);
    end
  endtask

  task automatic start_pkt();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d beats_left required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_lfsr = 16'hABCD;
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
      after_last = 0;
      beat_idx   = 0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", tvalid, 1);
        check("stall_hold", {tdata, tkeep, tlast, t_len, t_out_port}, prev_vec);
      end
      if (tvalid && after_last) begin
        if (exp_idle >= 0) check("idle_cycles", idle_run, exp_idle);
        after_last = 0;
      end else if (!tvalid && after_last) begin
        idle_run++;
      end
      if (tvalid && tready) begin
        if (rnd_mode) begin
          if (beat_idx == 0) begin
            cur_len = int'(t_len);
            check("rnd_len_range", (cur_len >= 64 && cur_len <= 1518), 1);
          end
          rlast = ((beat_idx + 1) == ((cur_len + KB - 1) / KB));
          rkeep = (rlast && (cur_len % KB != 0)) ? ((32'h1 << (cur_len % KB)) - 32'h1)
                                                  : 32'hFFFF_FFFF;
          check("rnd_len_const", t_len, cur_len);
          check("rnd_tdata", tdata, {16{mon_lfsr}});
          check("rnd_tlast", tlast, rlast);
          check("rnd_tkeep", tkeep, rkeep);
          mon_lfsr = lfsr_next(mon_lfsr);
          if (tlast) begin
            beat_idx = 0;
            rnd_pkts++;
          end else begin
            beat_idx++;
          end
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=no_beat", tdata[15:0]);
        end else begin
          e = exp_q.pop_front();
          check("beat_tdata", tdata, {16{e[70:55]}});
          check("beat_tkeep", tkeep, e[54:23]);
          check("beat_tlast", tlast, e[22]);
          check("beat_len", t_len, e[21:8]);
          check("beat_out_port", t_out_port, e[7:0]);
        end
        if (tlast) begin
          after_last = 1;
          idle_run   = 0;
        end
      end
      stall_prev = tvalid && !tready;
      prev_vec   = {tdata, tkeep, tlast, t_len, t_out_port};
    end
  end

  // ---------------- stimulus ----------------
  int len_tab[12] = '{1, 31, 32, 33, 64, 96, 100, 255, 256, 257, 500, 1000};
  int n;

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_random_len = 1'b0; cfg_length = 14'd64;
    cfg_gap = 8'd0; cfg_pkt_limit = 32'd0; cfg_out_port = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tkeep", tkeep, 32'hFFFF_FFFF);
    check("rst_tdata", tdata, {16{16'hABCD}});
    check("rst_pkt_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tuser", {t_len, t_in_port, t_out_port, t_in_vport, t_out_vport}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 64 B fixed: two full beats, hand-computed payload words
    push_beat(16'hABCD, 32'hFFFF_FFFF, 1'b0, 14'd64, 8'h5A);
    push_beat(16'hD5E6, 32'hFFFF_FFFF, 1'b1, 14'd64, 8'h5A);
    model_lfsr = lfsr_next(16'hD5E6);
    start_pkt();
    wait_drain(200);
    wait_idle(50);

    // 65 B: three beats, last keep 32'h1
    cfg_length = 14'd65; cfg_out_port = 8'hC3;
    push_packet(65);
    start_pkt();
    wait_drain(200);
    wait_idle(50);

    // length 0 is treated as a single byte
    cfg_length = 14'd0;
    push_packet(0);
    start_pkt();
    wait_drain(200);
    wait_idle(50);

    // random backpressure, mixed lengths, cfg disturbed while each packet is in flight
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      cfg_length   = 14'(len_tab[i % 12]);
      cfg_out_port = 8'(i * 7);
      cfg_gap      = 8'($urandom_range(0, 3));
      push_packet(len_tab[i % 12]);
      start_pkt();
      cfg_length   = 14'($urandom_range(1, 2000));
      cfg_out_port = 8'hEE;
      wait_drain(4000);
      wait_idle(100);
    end
    rnd_ready = 0;
    @(negedge clk);
    check("pkt_count_after_mixed", pkt_count, 43);

    // reset while beat 2 of a 10-beat packet is presented
    cfg_gap = 8'd0; cfg_length = 14'd320; cfg_out_port = 8'h11;
    push_beat(model_lfsr, 32'hFFFF_FFFF, 1'b0, 14'd320, 8'h11);
    start_pkt();
    wait_drain(100);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tvalid", tvalid, 0);
    check("midrst_pkt_count", pkt_count, 0);
    check("midrst_tdata", tdata, {16{16'hABCD}});
    @(posedge clk); #1 reset = 1'b0;
    model_lfsr = 16'hABCD;
    cfg_length = 14'd64;
    push_beat(16'hABCD, 32'hFFFF_FFFF, 1'b0, 14'd64, 8'h11);
    push_beat(16'hD5E6, 32'hFFFF_FFFF, 1'b1, 14'd64, 8'h11);
    model_lfsr = lfsr_next(16'hD5E6);
    start_pkt();
    wait_drain(200);
    wait_idle(50);
    check("postrst_pkt_count", pkt_count, 1);

    // back-to-back with limit 2, no gap
    do_reset();
    cfg_length = 14'd65; cfg_gap = 8'd0; cfg_pkt_limit = 32'd2; cfg_out_port = 8'h22;
    exp_idle = 0;
    push_packet(65);
    push_packet(65);
    @(posedge clk); #1 enable = 1'b1;
    wait_drain(400);
    repeat (10) @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_pkt_count", pkt_count, 2);
    check("b2b_tvalid", tvalid, 0);
    #1 enable = 1'b0;
    exp_idle = -1;

    // limit 3 with gap 4: five idle cycles between packets, then stop
    do_reset();
    cfg_length = 14'd40; cfg_gap = 8'd4; cfg_pkt_limit = 32'd3; cfg_out_port = 8'h33;
    exp_idle = 5;
    push_packet(40);
    push_packet(40);
    push_packet(40);
    @(posedge clk); #1 enable = 1'b1;
    wait_drain(400);
    repeat (20) @(negedge clk);
    check("limit_done", done, 1);
    check("limit_pkt_count", pkt_count, 3);
    check("limit_busy", busy, 0);
    check("limit_tvalid", tvalid, 0);
    #1 enable = 1'b0;
    exp_idle = -1;

    // random-length mode, random backpressure, 200 packets
    do_reset();
    cfg_random_len = 1'b1; cfg_gap = 8'd0; cfg_pkt_limit = 32'd200;
    mon_lfsr = 16'hABCD; rnd_pkts = 0; rnd_mode = 1; rnd_ready = 1;
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    while (!done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    #1 enable = 1'b0;
    repeat (4) @(negedge clk);
    check("rnd_done", done, 1);
    check("rnd_pkts", rnd_pkts, 200);
    check("rnd_pkt_count", pkt_count, 200);
    rnd_mode = 0; rnd_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
